jp_scan: RTL and testbench

JP_SCAN -- requirements
Module: jp_scan

---
 rtl/jp_pkg.sv | 29 ++
 rtl/jp_port.sv | 31 +++
 rtl/jp_scan.sv | 218 +++++++++++++++++++++
 tb/tb_jp_scan.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jp_pkg.sv
// Shared definitions for the NES-style joypad scanner: scan FSM encodings,
// button bit positions and the $4016/$4017 register selects.
package jp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_CLK_HI,
    ST_CLK_LO,
    ST_PUBLISH
  } scan_state_t;

  // Bit positions in btn1_out / btn2_out (1 = pressed) and in the serial order.
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam logic SEL_4016 = 1'b0;
  localparam logic SEL_4017 = 1'b1;

  localparam int POLL_W = 24;
  localparam int TMR_W  = 13;

endpackage

// File: rtl/jp_port.sv
// One CPU-visible pad register: reloads from the published buttons while the
// strobe is high, otherwise shifts out one button per read (1-filled).
module jp_port
  import jp_pkg::*;
(
  input  logic       clk_in,
  input  logic       nres_in,
  input  logic       strobe,
  input  logic       rd,
  input  logic [7:0] btn,
  output logic       d_out
);

  logic [7:0] shift;

  // NOTE: sequential state is assigned with non-blocking (<=) so every flop
  // samples pre-edge values; blocking assignments here would race.
  always_ff @(posedge clk_in or negedge nres_in) begin
    if (!nres_in) begin
      shift <= 8'hFF;
    end else if (strobe) begin
      shift <= btn;
    end else if (rd) begin
      shift <= {1'b1, shift[7:1]};
    end
  end

  // Read data is combinational so the CPU sees the bit in the strobe cycle.
  assign d_out = rd & shift[0];

endmodule

// File: rtl/jp_scan.sv
// NES-style dual joypad scanner with $4016/$4017 CPU read-out.
// Optional JP_SCAN_DEBOUNCE_EN: publish a pad only when two scans agree.
module jp_scan
  import jp_pkg::*;
#(
  parameter int POLL_DIV = 1666667,
  parameter int HALF_BIT = 600
) (
  input  logic       clk_in,
  input  logic       nres_in,
  input  logic       jp_data1_in,
  input  logic       jp_data2_in,
  output logic       jp_clk,
  output logic       jp_latch,
  output logic [7:0] btn1_out,
  output logic [7:0] btn2_out,
  output logic       btn_vld_out,
  input  logic       cpu_wr_in,
  input  logic       cpu_rd_in,
  input  logic       cpu_sel_in,
  input  logic [7:0] cpu_d_in,
  output logic [7:0] cpu_d_out
);

  localparam logic [POLL_W-1:0] POLL_LAST  = 24'(POLL_DIV - 1);
  localparam logic [TMR_W-1:0]  LATCH_LAST = 13'(2 * HALF_BIT - 1);
  localparam logic [TMR_W-1:0]  HALF_LAST  = 13'(HALF_BIT - 1);

  scan_state_t       state, state_nxt;
  logic [POLL_W-1:0] poll_cnt;
  logic [TMR_W-1:0]  tmr;
  logic [2:0]        bit_cnt;
  logic [1:0]        sync1, sync2;
  logic [7:0]        scan1, scan2;
  logic              poll_wrap;
  logic              tmr_clr;
  logic              smp;
  logic              pub;

  // Pad lines idle high (not pressed), so the synchronizers reset to 1.
  always_ff @(posedge clk_in or negedge nres_in) begin
    if (!nres_in) begin
      sync1 <= 2'b11;
      sync2 <= 2'b11;
    end else begin
      sync1 <= {sync1[0], jp_data1_in};
      sync2 <= {sync2[0], jp_data2_in};
    end
  end

  // Free-running poll divider; it keeps counting while a scan is in flight.
  assign poll_wrap = (poll_cnt == POLL_LAST);

  always_ff @(posedge clk_in or negedge nres_in) begin
    if (!nres_in) begin
      poll_cnt <= '0;
    end else if (poll_wrap) begin
      poll_cnt <= '0;
    end else begin
      poll_cnt <= poll_cnt + 24'd1;
    end
  end

  always_ff @(posedge clk_in or negedge nres_in) begin
    if (!nres_in) begin
      state    <= ST_IDLE;
      jp_latch <= 1'b0;
      jp_clk   <= 1'b0;
    end else begin
      state    <= state_nxt;
      jp_latch <= (state_nxt == ST_LATCH);
      jp_clk   <= (state_nxt == ST_CLK_HI);
    end
  end

  // NOTE: every signal driven here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    tmr_clr   = 1'b0;
    smp       = 1'b0;
    pub       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (poll_wrap) begin
          state_nxt = ST_LATCH;
          tmr_clr   = 1'b1;
        end
      end
      ST_LATCH: begin
        if (tmr == LATCH_LAST) begin
          smp       = 1'b1;
          tmr_clr   = 1'b1;
          state_nxt = ST_CLK_HI;
        end
      end
      ST_CLK_HI: begin
        if (tmr == HALF_LAST) begin
          tmr_clr   = 1'b1;
          state_nxt = ST_CLK_LO;
        end
      end
      ST_CLK_LO: begin
        if (tmr == HALF_LAST) begin
          smp       = 1'b1;
          tmr_clr   = 1'b1;
          state_nxt = (bit_cnt == 3'(BTN_RIGHT)) ? ST_PUBLISH : ST_CLK_HI;
        end
      end
      ST_PUBLISH: begin
        pub       = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge nres_in) begin
    if (!nres_in) begin
      tmr <= '0;
    end else if (tmr_clr || (state == ST_IDLE)) begin
      tmr <= '0;
    end else begin
      tmr <= tmr + 13'd1;
    end
  end

  // bit_cnt wraps back to 0 after bit 7, ready for the next scan.
  always_ff @(posedge clk_in or negedge nres_in) begin
    if (!nres_in) begin
      bit_cnt <= '0;
      scan1   <= '0;
      scan2   <= '0;
    end else if (smp) begin
      scan1[bit_cnt] <= ~sync1[1];
      scan2[bit_cnt] <= ~sync2[1];
      bit_cnt        <= bit_cnt + 3'd1;
    end
  end

`ifdef JP_SCAN_DEBOUNCE_EN
  logic [7:0] prev1, prev2;

  always_ff @(posedge clk_in or negedge nres_in) begin
    if (!nres_in) begin
      btn1_out    <= '0;
      btn2_out    <= '0;
      btn_vld_out <= 1'b0;
      prev1       <= '0;
      prev2       <= '0;
    end else begin
      btn_vld_out <= 1'b0;
      if (pub) begin
        if (scan1 == prev1) btn1_out <= scan1;
        if (scan2 == prev2) btn2_out <= scan2;
        btn_vld_out <= (scan1 == prev1) || (scan2 == prev2);
        prev1       <= scan1;
        prev2       <= scan2;
      end
    end
  end
`else
  always_ff @(posedge clk_in or negedge nres_in) begin
    if (!nres_in) begin
      btn1_out    <= '0;
      btn2_out    <= '0;
      btn_vld_out <= 1'b0;
    end else begin
      btn_vld_out <= pub;
      if (pub) begin
        btn1_out <= scan1;
        btn2_out <= scan2;
      end
    end
  end
`endif

  // CPU side: the strobe is shared by both pads and only written via $4016.
  logic strobe;
  logic rd1, rd2;
  logic bit1, bit2;
  logic unused_d;

  assign unused_d = ^cpu_d_in[7:1];

  always_ff @(posedge clk_in or negedge nres_in) begin
    if (!nres_in) begin
      strobe <= 1'b0;
    end else if (cpu_wr_in && (cpu_sel_in == SEL_4016)) begin
      strobe <= cpu_d_in[0];
    end
  end

  assign rd1 = cpu_rd_in & nres_in & (cpu_sel_in == SEL_4016);
  assign rd2 = cpu_rd_in & nres_in & (cpu_sel_in == SEL_4017);

  jp_port u_port1 (
    .clk_in  (clk_in),
    .nres_in (nres_in),
    .strobe  (strobe),
    .rd      (rd1),
    .btn     (btn1_out),
    .d_out   (bit1)
  );

  jp_port u_port2 (
    .clk_in  (clk_in),
    .nres_in (nres_in),
    .strobe  (strobe),
    .rd      (rd2),
    .btn     (btn2_out),
    .d_out   (bit2)
  );

  // Zero outside read cycles so the bus can be OR-combined.
  assign cpu_d_out = {7'b0, bit1 | bit2};

endmodule

// File: tb/tb_jp_scan.sv
// Scoreboard bench for jp_scan: a pad model answers latch/clock, stimulus
// pushes expected publishes and CPU reads, a monitor pops and compares.
module tb_jp_scan;
  import jp_pkg::*;

  localparam int POLL_DIV = 200;
  localparam int HALF_BIT = 4;

  logic       clk_in = 1'b0;
  logic       nres_in;
  logic       jp_data1_in, jp_data2_in;
  logic       jp_clk, jp_latch;
  logic [7:0] btn1_out, btn2_out;
  logic       btn_vld_out;
  logic       cpu_wr_in, cpu_rd_in, cpu_sel_in;
  logic [7:0] cpu_d_in, cpu_d_out;

  jp_scan #(.POLL_DIV(POLL_DIV), .HALF_BIT(HALF_BIT)) dut (
    .clk_in      (clk_in),
    .nres_in     (nres_in),
    .jp_data1_in (jp_data1_in),
    .jp_data2_in (jp_data2_in),
    .jp_clk      (jp_clk),
    .jp_latch    (jp_latch),
    .btn1_out    (btn1_out),
    .btn2_out    (btn2_out),
    .btn_vld_out (btn_vld_out),
    .cpu_wr_in   (cpu_wr_in),
    .cpu_rd_in   (cpu_rd_in),
    .cpu_sel_in  (cpu_sel_in),
    .cpu_d_in    (cpu_d_in),
    .cpu_d_out   (cpu_d_out)
  );

  always #5 clk_in = ~clk_in;

  // Pad model: 1 in pat = pressed; line is low while the current bit is pressed.
  logic [7:0] pat1 = 8'h00, pat2 = 8'h00;
  logic [7:0] sh1 = 8'h00, sh2 = 8'h00;

  always @(posedge jp_latch or posedge jp_clk) begin
    if (jp_latch) begin
      sh1 = pat1;
      sh2 = pat2;
    end else begin
      sh1 = sh1 >> 1;
      sh2 = sh2 >> 1;
    end
  end

  assign jp_data1_in = ~sh1[0];
  assign jp_data2_in = ~sh2[0];

  typedef struct packed {
    logic [7:0] b1;
    logic [7:0] b2;
  } pub_t;

  pub_t pub_q[$];
  logic rd_q[$];
  pub_t mon_pub;
  logic mon_rd;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [7:0] m_btn1 = 8'h00, m_btn2 = 8'h00;
`ifdef JP_SCAN_DEBOUNCE_EN
  logic [7:0] m_prev1 = 8'h00, m_prev2 = 8'h00;
`endif

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (nres_in === 1'b1) begin
      if (btn_vld_out) begin
        if (pub_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_vld: got btn %h/%h expected no btn_vld_out", btn1_out, btn2_out);
        end else begin
          mon_pub = pub_q.pop_front();
          check("publish", {btn1_out, btn2_out}, {mon_pub.b1, mon_pub.b2});
        end
      end
      if (cpu_rd_in) begin
        if (rd_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_read: got %h expected no read", cpu_d_out);
        end else begin
          mon_rd = rd_q.pop_front();
          check("cpu_read", cpu_d_out, {7'b0, mon_rd});
        end
      end else begin
        check("bus_idle", cpu_d_out, 8'h00);
      end
    end
  end

  // Sets the pad pattern for the next scan and queues the publish it should cause.
  task automatic expect_scan(input logic [7:0] p1, input logic [7:0] p2);
`ifdef JP_SCAN_DEBOUNCE_EN
    logic u1, u2;
    pat1 = p1;
    pat2 = p2;
    u1 = (p1 == m_prev1);
    u2 = (p2 == m_prev2);
    m_prev1 = p1;
    m_prev2 = p2;
    if (u1) m_btn1 = p1;
    if (u2) m_btn2 = p2;
    if (u1 || u2) pub_q.push_back({m_btn1, m_btn2});
`else
    pat1 = p1;
    pat2 = p2;
    m_btn1 = p1;
    m_btn2 = p2;
    pub_q.push_back({m_btn1, m_btn2});
`endif
  endtask

  task automatic model_reset();
    m_btn1 = 8'h00;
    m_btn2 = 8'h00;
`ifdef JP_SCAN_DEBOUNCE_EN
    m_prev1 = 8'h00;
    m_prev2 = 8'h00;
`endif
  endtask

  task automatic wait_latch(output int cyc);
    cyc = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk_in);
      cyc++;
      @(negedge clk_in);
      if (jp_latch) return;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL latch_timeout: got no jp_latch in %0d cycles expected a scan", cyc);
  endtask

  task automatic run_scan(input logic [7:0] p1, input logic [7:0] p2);
    int cyc;
    expect_scan(p1, p2);
    wait_latch(cyc);
    repeat (75) @(negedge clk_in);
    check("scan_drained", pub_q.size(), 0);
    check("btn1_state", btn1_out, m_btn1);
    check("btn2_state", btn2_out, m_btn2);
  endtask

  task automatic cpu_op(input logic wr, input logic rd, input logic sel, input logic d0,
                        input logic exp);
    @(posedge clk_in);
    #1;
    if (rd) rd_q.push_back(exp);
    cpu_wr_in  = wr;
    cpu_rd_in  = rd;
    cpu_sel_in = sel;
    cpu_d_in   = {7'b0, d0};
  endtask

  task automatic cpu_idle();
    @(posedge clk_in);
    #1;
    cpu_wr_in = 1'b0;
    cpu_rd_in = 1'b0;
    cpu_d_in  = 8'h00;
  endtask

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  initial begin
    #2_000_000;
    n_cmp++;
    n_bad++;
    $display("FAIL watchdog: got no end of test expected completion");
    summary();
    $finish;
  end

  initial begin
    int   cyc, w, rises, hi;
    logic prev_clk;
    int   exp_seq[10] = '{1, 0, 0, 1, 0, 0, 0, 0, 1, 1};

    nres_in    = 1'b0;
    cpu_wr_in  = 1'b0;
    cpu_rd_in  = 1'b1;
    cpu_sel_in = SEL_4016;
    cpu_d_in   = 8'h00;
    repeat (3) @(negedge clk_in);
    check("rst_jp_clk", jp_clk, 1'b0);
    check("rst_jp_latch", jp_latch, 1'b0);
    check("rst_btn1", btn1_out, 8'h00);
    check("rst_btn2", btn2_out, 8'h00);
    check("rst_vld", btn_vld_out, 1'b0);
    check("rst_cpu_d", cpu_d_out, 8'h00);
    cpu_rd_in = 1'b0;
    nres_in   = 1'b1;

    // First scan, lines idle high: timing of latch and clock pulses.
    expect_scan(8'h00, 8'h00);
    wait_latch(cyc);
    check("first_latch_cycle", cyc, POLL_DIV);
    w = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_in);
      if (!jp_latch) break;
      w++;
    end
    check("latch_width", w, 2 * HALF_BIT);
    rises = 0;
    hi = 0;
    prev_clk = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (jp_clk) hi++;
      if (jp_clk && !prev_clk) rises++;
      prev_clk = jp_clk;
      @(negedge clk_in);
    end
    check("clk_pulses", rises, 7);
    check("clk_high_cycles", hi, 7 * HALF_BIT);
    repeat (10) @(negedge clk_in);
    check("first_drained", pub_q.size(), 0);
    check("first_btn1", btn1_out, 8'h00);

    // Pad 1 bits 0 and 3, pad 2 bit 7; two scans so debounce also accepts it.
    run_scan(8'h09, 8'h80);
    run_scan(8'h09, 8'h80);
    check("btn1_09", btn1_out, 8'h09);
    check("btn2_80", btn2_out, 8'h80);

    // Strobe pulse then serial read-out of pad 1.
    cpu_op(1'b1, 1'b0, SEL_4016, 1'b1, 1'b0);
    cpu_op(1'b1, 1'b0, SEL_4016, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cpu_op(1'b0, 1'b1, SEL_4016, 1'b0, exp_seq[i][0]);
    // $4017 writes must not touch the strobe; pad 2 shifts out 8'h80.
    cpu_op(1'b1, 1'b0, SEL_4017, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) cpu_op(1'b0, 1'b1, SEL_4017, 1'b0, (i >= 7));
    // Strobe held high: reads return A and never shift.
    cpu_op(1'b1, 1'b0, SEL_4016, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cpu_op(1'b0, 1'b1, SEL_4016, 1'b0, 1'b1);
    cpu_op(1'b1, 1'b0, SEL_4016, 1'b0, 1'b0);
    cpu_op(1'b0, 1'b1, SEL_4016, 1'b0, 1'b1);
    cpu_op(1'b0, 1'b1, SEL_4016, 1'b0, 1'b0);
    cpu_idle();
    @(negedge clk_in);
    check("rd_drained", rd_q.size(), 0);

    // Reset during bit 4 of a scan.
    wait_latch(cyc);
    rises = 0;
    prev_clk = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_in);
      if (jp_clk && !prev_clk) rises++;
      prev_clk = jp_clk;
      if (rises == 4) break;
    end
    check("abort_point", rises, 4);
    nres_in = 1'b0;
    #1;
    check("abort_jp_clk", jp_clk, 1'b0);
    check("abort_jp_latch", jp_latch, 1'b0);
    check("abort_btn1", btn1_out, 8'h00);
    check("abort_btn2", btn2_out, 8'h00);
    check("abort_vld", btn_vld_out, 1'b0);
    model_reset();
    repeat (3) @(negedge clk_in);
    expect_scan(8'h09, 8'h80);
    nres_in = 1'b1;
    wait_latch(cyc);
    check("latch_after_reset", cyc, POLL_DIV);
    repeat (75) @(negedge clk_in);
    check("post_reset_drained", pub_q.size(), 0);
    check("post_reset_btn1", btn1_out, m_btn1);
    check("post_reset_btn2", btn2_out, m_btn2);

    // Glitchy then stable pad-1 pattern.
    run_scan(8'h01, 8'h00);
    run_scan(8'h00, 8'h00);
    run_scan(8'h01, 8'h00);
    run_scan(8'h01, 8'h00);
    check("stable_btn1", btn1_out, 8'h01);

    summary();
    $finish;
  end

endmodule
